// File: rtl/reg_bank.sv
// Register bank: DEPTH x WIDTH, one write port, two registered read ports, hardware clear sweep.
// Read latency 1 cycle; busy is high for DEPTH cycles during a sweep, writes then dropped; REG_BANK_BYPASS_EN selects read-during-write result.
module reg_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              clr_req,
  output logic              busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  rd_a_nxt, rd_b_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (clr_req) state_nxt = CLEAR;
      CLEAR: if (idx == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The sweep owns the single write port while busy; user writes are dropped.
  always_comb begin
    busy    = (state == CLEAR);
    wr_en   = we;
    wr_addr = waddr;
    wr_data = wdata;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = idx;
      wr_data = '0;
    end
  end

  // Index wraps to 0 on the final sweep edge since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               idx <= '0;
    else if (state == CLEAR)  idx <= idx + ADDR_W'(1);
    else if (clr_req)         idx <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef REG_BANK_BYPASS_EN
  always_comb begin
    rd_a_nxt = (wr_en && (wr_addr == raddr_a)) ? wr_data : mem[raddr_a];
    rd_b_nxt = (wr_en && (wr_addr == raddr_b)) ? wr_data : mem[raddr_b];
  end
`else
  always_comb begin
    rd_a_nxt = mem[raddr_a];
    rd_b_nxt = mem[raddr_b];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= rd_a_nxt;
      rdata_b <= rd_b_nxt;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: stimulus pushes model-predicted outputs per edge, a monitor pops and compares.
module tb_reg_bank;
  localparam int W = 8;
  localparam int D = 4;
  localparam int A = 2;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         we = 0;
  logic [A-1:0] waddr = '0;
  logic [W-1:0] wdata = '0;
  logic [A-1:0] raddr_a = '0;
  logic [A-1:0] raddr_b = '0;
  logic         clr_req = 0;
  logic [W-1:0] rdata_a, rdata_b;
  logic         busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bsy;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] m_mem [D];
  int           sweep_left = 0;

  reg_bank #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .clr_req(clr_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: applies one clock edge given the inputs present at that edge.
  task automatic model_edge(input bit r, input bit w, input logic [A-1:0] wa, input logic [W-1:0] wd,
                            input logic [A-1:0] ra, input logic [A-1:0] rb, input bit c);
    logic [W-1:0] old [D];
    exp_t e;
    if (!r) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      sweep_left = 0;
      e.a = '0; e.b = '0; e.bsy = 1'b0;
      q.push_back(e);
      return;
    end
    old = m_mem;
    if (sweep_left > 0) begin
      m_mem[D - sweep_left] = '0;
      sweep_left--;
    end else begin
      if (w) m_mem[wa] = wd;
      if (c) sweep_left = D;
    end
`ifdef REG_BANK_BYPASS_EN
    e.a = m_mem[ra];
    e.b = m_mem[rb];
`else
    e.a = old[ra];
    e.b = old[rb];
`endif
    e.bsy = (sweep_left > 0);
    q.push_back(e);
  endtask

  // Drive inputs just after an edge, let one edge pass, record the expectation.
  task automatic cyc(input bit r, input bit w, input int wa, input int wd,
                     input int ra, input int rb, input bit c);
    rst_n = r; we = w; waddr = A'(wa); wdata = W'(wd);
    raddr_a = A'(ra); raddr_b = A'(rb); clr_req = c;
    @(posedge clk);
    #1;
    model_edge(r, w, A'(wa), W'(wd), A'(ra), A'(rb), c);
  endtask

  task automatic rd(input int ra, input int rb);
    cyc(1, 0, 0, 0, ra, rb, 0);
  endtask

  // Asserts reset mid-cycle and checks the outputs clear without any clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rdata_a", rdata_a, '0);
    check("async_rst_rdata_b", rdata_b, '0);
    check("async_rst_busy", W'(busy), '0);
    q.delete();
    model_edge(0, 0, '0, '0, '0, '0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rdata_a", rdata_a, e.a);
        check("rdata_b", rdata_b, e.b);
        check("busy", W'(busy), W'(e.bsy));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    foreach (m_mem[i]) m_mem[i] = '0;
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 2, 3, 0);
    // basic write/read
    cyc(1, 1, 2, 'hA5, 0, 0, 0);
    cyc(1, 1, 1, 'h3C, 0, 0, 0);
    rd(2, 1);
    rd(2, 1);
    // mid-cycle reset with data present
    async_reset();
    cyc(0, 0, 0, 0, 2, 1, 0);
    for (int k = 0; k < D; k++) rd(k, D - 1 - k);
    // read during write
    cyc(1, 1, 3, 'h11, 0, 0, 0);
    cyc(1, 1, 3, 'h77, 3, 3, 0);
    rd(3, 3);
    rd(3, 0);
    // full clear sweep
    for (int k = 0; k < D; k++) cyc(1, 1, k, 'hFF, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < D + 2; k++) rd(k % D, (k + 1) % D);
    // writes and clr_req while busy
    for (int k = 0; k < D; k++) cyc(1, 1, k, 'hFF, 0, 0, 0);
    cyc(1, 0, 0, 0, 3, 2, 1);
    cyc(1, 1, 3, 'h55, 3, 2, 1);
    cyc(1, 1, 3, 'h55, 3, 3, 1);
    cyc(1, 0, 0, 0, 3, 0, 1);
    cyc(1, 0, 0, 0, 3, 1, 0);
    rd(3, 2);
    rd(3, 3);
    // simultaneous write and clear in idle
    cyc(1, 1, 2, 'h9A, 2, 2, 1);
    for (int k = 0; k < D + 1; k++) rd(2, k % D);
    // reset in the middle of a sweep
    cyc(1, 1, 2, 'hFF, 0, 0, 0);
    cyc(1, 1, 3, 'hFF, 0, 0, 0);
    cyc(1, 0, 0, 0, 2, 3, 1);
    rd(2, 3);
    async_reset();
    cyc(0, 0, 0, 0, 2, 3, 0);
    for (int k = 0; k < D; k++) rd(k, 3 - k);
    cyc(1, 1, 1, 'h42, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < D + 2; k++) rd(1, k % D);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      cyc(1, 1'($urandom_range(0, 1)), $urandom_range(0, D - 1), $urandom_range(0, 255),
          $urandom_range(0, D - 1), $urandom_range(0, D - 1), ($urandom_range(0, 9) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
